// File: rtl/nlp16af_bus_unit.sv
// Registered multi-cycle memory-bus sequencer for the nlp16af core: read, write and
// two-word instruction fetch with ack wait states and a strobe timeout.
module nlp16af_bus_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_kind,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_ir1,
    output logic [DATA_W-1:0] o_ir2,
    output logic              o_rd,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_bus,
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_ack
);

    typedef enum logic [1:0] {IDLE, STROBE, GAP, RESP} state_t;

    localparam logic [1:0] K_FETCH = 2'b00;
    localparam logic [1:0] K_READ  = 2'b01;
    localparam logic [1:0] K_WRITE = 2'b10;
    localparam logic [1:0] K_ILL   = 2'b11;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic              word1_q, word1_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;

    logic              rdy_d, rv_d, err_d, rd_d, wr_d;
    logic [DATA_W-1:0] rdata_d, ir1_d, ir2_d, bus_d;
    logic [ADDR_W-1:0] addr_d;

    // Every output is a register; this block computes all next values.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        word1_d  = word1_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        rdy_d    = o_req_ready;
        rv_d     = o_rsp_valid;
        err_d    = o_rsp_err;
        rd_d     = o_rd;
        wr_d     = o_wr;
        rdata_d  = o_rsp_rdata;
        ir1_d    = o_ir1;
        ir2_d    = o_ir2;
        bus_d    = o_bus;
        addr_d   = o_address;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                rv_d  = 1'b0;
                err_d = 1'b0;
                if (i_req_valid) begin
                    kind_d  = i_req_kind;
                    cnt_d   = 8'd0;
                    word1_d = 1'b0;
                    rdy_d   = 1'b0;
                    if (i_req_kind == K_ILL) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = STROBE;
                        addr_d  = i_req_addr;
                        if (i_req_kind == K_WRITE) begin
                            wr_d  = 1'b1;
                            bus_d = i_req_wdata;
                        end else begin
                            rd_d = 1'b1;
                        end
                    end
                end
            end
            STROBE: begin
                if (i_ack) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (kind_q == K_FETCH && !word1_q) begin
                        shadow_d = i_bus;
                        addr_d   = o_address + ADDR_ONE;
                        word1_d  = 1'b1;
                        state_d  = GAP;
                    end else begin
                        if (kind_q == K_READ) rdata_d = i_bus;
                        // Both IR words land on one edge so a failed fetch never splits them.
                        if (kind_q == K_FETCH) begin
                            ir1_d = shadow_q;
                            ir2_d = i_bus;
                        end
                        state_d = RESP;
                        rv_d    = 1'b1;
                        err_d   = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RESP;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                cnt_d   = 8'd0;
                rd_d    = 1'b1;
                state_d = STROBE;
            end
            RESP: begin
                rv_d    = 1'b0;
                err_d   = 1'b0;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            kind_q      <= K_FETCH;
            word1_q     <= 1'b0;
            cnt_q       <= 8'd0;
            shadow_q    <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rd        <= 1'b0;
            o_wr        <= 1'b0;
            o_rsp_rdata <= '0;
            o_ir1       <= '0;
            o_ir2       <= '0;
            o_bus       <= '0;
            o_address   <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            word1_q     <= word1_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            o_req_ready <= rdy_d;
            o_rsp_valid <= rv_d;
            o_rsp_err   <= err_d;
            o_rd        <= rd_d;
            o_wr        <= wr_d;
            o_rsp_rdata <= rdata_d;
            o_ir1       <= ir1_d;
            o_ir2       <= ir2_d;
            o_bus       <= bus_d;
            o_address   <= addr_d;
        end
    end

endmodule
